// File: rtl/pt_write_buffer_if.sv
// pt_write_buffer_if
//   Bundles the transform-side write port, the ptflag back-pressure line,
//   the arbiter grant and the ZBT write port of pt_write_buffer.
//
//   Handshake: the transform may pulse pt_wr for one cycle per write. It
//   should stop issuing writes when it sees ptflag=0. It reacts one cycle
//   late, and the buffer has room for that. The arbiter raises mem_grant
//   for a write slot. One cycle after a grant that finds data buffered,
//   mem_we pulses for one cycle with mem_addr/mem_data valid. There is no
//   ready back to the block: every mem_we is taken by the memory.
//
//   Modports:
//     master - environment side (transform + arbiter + memory)
//     slave  - the write buffer itself
interface pt_write_buffer_if;
  logic [17:0] pt_pixel_write;
  logic [9:0]  pt_x;
  logic [8:0]  pt_y;
  logic        pt_wr;
  logic        ptflag;
  logic        mem_grant;
  logic [18:0] mem_addr;
  logic [17:0] mem_data;
  logic        mem_we;
  logic        overflow;
  logic        idle;

  modport master (
    output pt_pixel_write, pt_x, pt_y, pt_wr, mem_grant,
    input  ptflag, mem_addr, mem_data, mem_we, overflow, idle
  );

  modport slave (
    input  pt_pixel_write, pt_x, pt_y, pt_wr, mem_grant,
    output ptflag, mem_addr, mem_data, mem_we, overflow, idle
  );
endinterface

// File: rtl/pt_write_buffer.sv
// pt_write_buffer
//   This block takes pixel writes from the projective transform and drops
//   any whose coordinates are off-screen. For the rest, it turns (x, y) into
//   a linear ZBT address and queues {addr, pixel} in a FIFO. It drains the
//   FIFO one entry per arbiter write grant, and it drives ptflag
//   back-pressure to the transform.
//
// Ports:
//   clk, reset  - system clock, synchronous active-high reset
//   bus (slave) - pt_pixel_write/pt_x/pt_y/pt_wr in, ptflag out,
//                 mem_grant in, mem_addr/mem_data/mem_we out,
//                 overflow (sticky lost-write flag) out, idle out
//   drop_count  - (PT_WRITE_BUFFER_STATS_EN only) off-screen writes seen,
//                 saturating
//   write_count - (PT_WRITE_BUFFER_STATS_EN only) mem_we pulses issued,
//                 saturating
//
// Optional feature macro: PT_WRITE_BUFFER_STATS_EN
module pt_write_buffer #(
  parameter int DEPTH_LOG2 = 4,
  parameter int H_RES      = 640,
  parameter int V_RES      = 480
) (
  input  logic               clk,
  input  logic               reset,
  pt_write_buffer_if.slave   bus
`ifdef PT_WRITE_BUFFER_STATS_EN
  ,
  output logic [15:0]        drop_count,
  output logic [19:0]        write_count
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;  // FIFO count, 0..DEPTH
  localparam int UW    = DEPTH_LOG2 + 2;  // used, 0..DEPTH+1
  localparam logic [9:0] H_LIM = 10'(H_RES);
  localparam logic [8:0] V_LIM = 9'(V_RES);

  // Accept: range filter and address generation on the sampled strobe
  logic        in_range;
  logic        accept;
  logic [18:0] addr_calc;
  logic [18:0] y_ext;
  logic [18:0] x_ext;

  assign in_range = (bus.pt_x < H_LIM) && (bus.pt_y < V_LIM);
  assign accept   = bus.pt_wr && in_range;
  assign y_ext    = {10'b0, bus.pt_y};
  assign x_ext    = {9'b0, bus.pt_x};

  generate
    if (H_RES == 640) begin : g_addr_640
      // y*640 = y*512 + y*128
      assign addr_calc = (y_ext << 9) + (y_ext << 7) + x_ext;
    end else begin : g_addr_mul
      assign addr_calc = y_ext * 19'(H_RES) + x_ext;
    end
  endgenerate

  // Address stage register: one write in flight ahead of the FIFO push
  logic        s2_valid;
  logic [36:0] s2_entry;

  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_entry <= '0;
    end else begin
      s2_valid <= accept;
      if (accept) s2_entry <= {addr_calc, bus.pt_pixel_write};
    end
  end

  // FIFO
  logic [36:0]           fifo_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [CW-1:0]         count;
  logic [CW-1:0]         count_next;
  logic                  full;
  logic                  empty;
  logic                  pop;
  logic                  push;
  logic                  lost;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign pop   = bus.mem_grant && !empty;
  // When full, a pop in the same cycle frees the slot the push needs.
  assign push  = s2_valid && (!full || pop);
  assign lost  = s2_valid && full && !pop;

  always_comb begin
    count_next = count;
    if (push && !pop)      count_next = count + 1'b1;
    else if (pop && !push) count_next = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= s2_entry;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
    end
  end

  // Occupancy, back-pressure and the sticky lost-write flag
  logic [UW-1:0] used;
  logic          overflow_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      used       <= '0;
      overflow_q <= 1'b0;
    end else begin
      used <= UW'(count_next) + UW'(accept);
      if (lost) overflow_q <= 1'b1;
    end
  end

  // Two free slots remain when ptflag drops. That covers the write already
  // issued and the one the transform sends before it sees the flag.
  assign bus.ptflag   = (used <= UW'(DEPTH - 3));
  assign bus.overflow = overflow_q;

  // Drain: a grant pops this cycle and the write appears on the next cycle
  logic        mem_we_q;
  logic [18:0] mem_addr_q;
  logic [17:0] mem_data_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
    end else begin
      mem_we_q <= pop;
      if (pop) {mem_addr_q, mem_data_q} <= fifo_mem[rd_ptr];
    end
  end

  assign bus.mem_we   = mem_we_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_data = mem_data_q;
  assign bus.idle     = (used == '0) && !mem_we_q;

`ifdef PT_WRITE_BUFFER_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_count  <= '0;
      write_count <= '0;
    end else begin
      if (bus.pt_wr && !in_range && (drop_count != '1))
        drop_count <= drop_count + 1'b1;
      if (mem_we_q && (write_count != '1))
        write_count <= write_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pt_write_buffer.sv
// tb_pt_write_buffer
//   Directed bench for pt_write_buffer at its default parameters
//   (depth 16, 640x480). Expected writes are queued as {addr, pixel} when
//   they are driven. A negedge monitor retires them against mem_we.
module tb_pt_write_buffer;

  logic clk;
  logic reset;
  pt_write_buffer_if bus ();
`ifdef PT_WRITE_BUFFER_STATS_EN
  logic [15:0] drop_count;
  logic [19:0] write_count;
`endif

  pt_write_buffer dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus)
`ifdef PT_WRITE_BUFFER_STATS_EN
    ,
    .drop_count  (drop_count),
    .write_count (write_count)
`endif
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  // Scoreboard
  logic [36:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int we_total = 0;
  int last_we_cycle = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cycle);
    end
  endtask

  function automatic logic [18:0] addr_of(input int x, input int y);
    return 19'(y * 640 + x);
  endfunction

  always @(negedge clk) begin
    if (!reset && bus.mem_we) begin
      logic [36:0] e;
      we_total++;
      last_we_cycle = cycle;
      check("we_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("mem_addr", 64'(bus.mem_addr), 64'(e[36:18]));
        check("mem_data", 64'(bus.mem_data), 64'(e[17:0]));
      end
    end
  end

  // Driver tasks
  task automatic drive_write(input logic [17:0] pix, input int x, input int y, input bit expect_kept);
    bus.pt_pixel_write = pix;
    bus.pt_x = 10'(x);
    bus.pt_y = 9'(y);
    bus.pt_wr = 1'b1;
    if (expect_kept) exp_q.push_back({addr_of(x, y), pix});
    @(posedge clk); #1;
    bus.pt_wr = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) begin @(posedge clk); #1; end
    idle_cycles(3);
    check("drain_left", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_cycles(3);
    reset = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    int t0, we0, win;
    bit f0, f1;

    bus.pt_pixel_write = '0;
    bus.pt_x = '0;
    bus.pt_y = '0;
    bus.pt_wr = 1'b0;
    bus.mem_grant = 1'b0;
    reset = 1'b1;
    idle_cycles(3);
    reset = 1'b0;

    // Reset values
    check("rst_ptflag", 64'(bus.ptflag), 64'd1);
    check("rst_idle", 64'(bus.idle), 64'd1);
    check("rst_we", 64'(bus.mem_we), 64'd0);
    check("rst_addr", 64'(bus.mem_addr), 64'd0);
    check("rst_data", 64'(bus.mem_data), 64'd0);
    check("rst_overflow", 64'(bus.overflow), 64'd0);

    // Single write, grant held: 3-cycle latency, address 2*640+3
    bus.mem_grant = 1'b1;
    we0 = we_total;
    t0 = cycle;
    drive_write(18'h2A5A5, 3, 2, 1'b1);
    check("single_addr_model", 64'(addr_of(3, 2)), 64'd1283);
    wait_drain();
    check("single_we_count", 64'(we_total - we0), 64'd1);
    check("single_latency", 64'(last_we_cycle - t0), 64'd3);
    check("single_idle", 64'(bus.idle), 64'd1);

    // Corners in order, then two off-screen drops
    we0 = we_total;
    drive_write(18'h3FFFF, 639, 479, 1'b1);
    drive_write(18'h00001, 0, 0, 1'b1);
    drive_write(18'h11111, 640, 0, 1'b0);
    drive_write(18'h22222, 0, 480, 1'b0);
    wait_drain();
    check("corner_we_count", 64'(we_total - we0), 64'd2);
    check("corner_last_addr", 64'(bus.mem_addr), 64'd0);
    check("corner_overflow", 64'(bus.overflow), 64'd0);
`ifdef PT_WRITE_BUFFER_STATS_EN
    check("drop_count", 64'(drop_count), 64'd2);
    check("write_count", 64'(write_count), 64'd3);
`endif

    // No grants: 16 fit, ptflag drops once used reaches 14, 17th overflows
    bus.mem_grant = 1'b0;
    idle_cycles(1);
    for (int i = 0; i < 17; i++) begin
      drive_write(18'h10000 + 18'(i), i * 7, i * 11, i < 16);
      check($sformatf("fill_ptflag_%0d", i + 1), 64'(bus.ptflag), 64'(i + 1 <= 13));
      check("fill_overflow_early", 64'(bus.overflow), 64'd0);
    end
    idle_cycles(1);
    check("fill_overflow", 64'(bus.overflow), 64'd1);
    check("fill_ptflag_full", 64'(bus.ptflag), 64'd0);
    check("fill_idle", 64'(bus.idle), 64'd0);
    we0 = we_total;
    bus.mem_grant = 1'b1;
    wait_drain();
    check("fill_we_count", 64'(we_total - we0), 64'd16);
    check("fill_overflow_sticky", 64'(bus.overflow), 64'd1);

    // Continuous writes honouring ptflag one cycle late, grant alternating
    do_reset();
    bus.mem_grant = 1'b0;
    f0 = bus.ptflag;
    f1 = bus.ptflag;
    win = 0;
    for (int c = 0; c < 60; c++) begin
      bus.pt_wr = f1;
      bus.pt_pixel_write = 18'h20000 + 18'(c);
      bus.pt_x = 10'(c);
      bus.pt_y = 9'd5;
      if (f1) exp_q.push_back({addr_of(c, 5), 18'h20000 + 18'(c)});
      bus.mem_grant = c[0];
      @(posedge clk); #1;
      if (c >= 30 && bus.mem_we) win++;
      f1 = f0;
      f0 = bus.ptflag;
    end
    bus.pt_wr = 1'b0;
    check("alt_we_window", 64'(win), 64'd15);
    check("alt_overflow", 64'(bus.overflow), 64'd0);
    bus.mem_grant = 1'b1;
    wait_drain();
    check("alt_overflow_end", 64'(bus.overflow), 64'd0);

    // Full FIFO with push and pop together: push accepted, no overflow
    do_reset();
    bus.mem_grant = 1'b0;
    for (int i = 0; i < 17; i++) drive_write(18'h30000 + 18'(i), i, 100 + i, 1'b1);
    check("full_ptflag", 64'(bus.ptflag), 64'd0);
    bus.mem_grant = 1'b1;
    idle_cycles(1);
    bus.mem_grant = 1'b0;
    check("full_pp_we", 64'(bus.mem_we), 64'd1);
    check("full_pp_overflow", 64'(bus.overflow), 64'd0);
    idle_cycles(2);
    check("full_pp_ptflag", 64'(bus.ptflag), 64'd0);
    we0 = we_total;
    bus.mem_grant = 1'b1;
    wait_drain();
    check("full_pp_we_rest", 64'(we_total - we0), 64'd16);
    check("full_pp_overflow_end", 64'(bus.overflow), 64'd0);

    // Reset with 5 queued entries: nothing from them is ever written
    bus.mem_grant = 1'b0;
    for (int i = 0; i < 5; i++) drive_write(18'h05000 + 18'(i), 10 + i, 20, 1'b0);
    idle_cycles(2);
    check("preq_idle", 64'(bus.idle), 64'd0);
    we0 = we_total;
    reset = 1'b1;
    idle_cycles(1);
    check("mid_rst_ptflag", 64'(bus.ptflag), 64'd1);
    check("mid_rst_idle", 64'(bus.idle), 64'd1);
    check("mid_rst_we", 64'(bus.mem_we), 64'd0);
    reset = 1'b0;
    bus.mem_grant = 1'b1;
    idle_cycles(10);
    check("mid_rst_no_we", 64'(we_total - we0), 64'd0);
    check("mid_rst_idle_after", 64'(bus.idle), 64'd1);
`ifdef PT_WRITE_BUFFER_STATS_EN
    check("mid_rst_drop_count", 64'(drop_count), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
